reg_write_arbiter: RTL
======================

# reg_write_arbiter

Round-robin write arbiter and sequencer for a small bank of enable-gated, resettable registers. NUM_REQ requesters compete for one shared write port; one winner per cycle is accepted with a valid/ready handshake, staged for one cycle, then written by asserting the target entry's clock enable. Sits between producer blocks and the register bank, which is built from the team's REGISTER_R_CE cells; a single combinational read port exposes entry contents.

## Interface
- N, 32, data width of each entry
- NUM_REQ, 4, number of requesters (≥2)
- DEPTH, 8, number of register entries (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), entry address width (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester write request
- req_ready  out  NUM_REQ  per-requester grant; transfer when valid & ready
- req_addr  in  NUM_REQ*ADDR_W  packed target addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*N  packed write data, requester i at [i*N +: N]
- rd_addr  in  ADDR_W  read address
- rd_data  out  N  contents of entry rd_addr (combinational from register outputs)
- wr_pending  out  1  staged write present this cycle
- wr_count  out  16  accepted-write counter, saturating at 16'hFFFF

## Operation
- Priority pointer ptr (ADDR-independent, range 0..NUM_REQ-1): search req_valid starting at ptr, wrapping; first valid index wins.
- req_ready is one-hot or zero; req_ready[i]=1 only if req_valid[i]=1 and i is the winner. Depends combinationally on req_valid; requesters must not make valid depend on ready.
- Stage never stalls: one acceptance possible every cycle, including back-to-back from same requester when no other is valid.
- On acceptance of requester g: ptr ← (g+1) mod NUM_REQ; stage ← {valid=1, addr, data}; wr_count ← wr_count+1 unless saturated. No acceptance: ptr held, stage valid ← 0.
- Staged write: entry stage.addr gets ce=1, d=stage.data; all other entries ce=0.
- Consecutive writes to one address: later one wins (applied in acceptance order).
- Requester may drop or change valid/addr/data while not granted; no acceptance recorded.
- Reset: ptr=0, stage valid=0 (staged write discarded), all entries=0, wr_count=0, hence rd_data=0, wr_pending=0, req_ready follows arbitration from ptr=0 in the same cycle rst is low again. While rst=1, req_ready=0 and nothing is accepted.

## Timing
- Cycle t: req_valid[g]&req_ready[g]=1 → edge end of t captures stage.
- Cycle t+1: wr_pending=1; entry ce asserted → edge end of t+1 writes entry.
- Cycle t+2: rd_data (rd_addr=addr) shows new value. Write latency accept→visible = 2 edges; no read bypass of staged data.
- wr_count increments at edge end of acceptance cycle (visible t+1).
- Rst asserted in t+1 with staged write: write dropped; entry reads 0 in t+2.

## Structure
- Shared package reg_arb_pkg: wr_count width constant (16), stage struct typedef {valid, addr, data} parameterised by widths via localparams in the module if package can't carry them.
- One sub-module natural: rr_arbiter (req vector + ptr in, one-hot grant + grant index out, purely combinational); ptr register lives in reg_write_arbiter.
- Entries instantiated as DEPTH × REGISTER_R_CE with rst tied to rst.

## Test plan
- Reset: rst=1 two cycles with all valid=1 → req_ready=0, rd_data=0 for every rd_addr, wr_count=0, wr_pending=0.
- Single write: req 2 writes addr 3 data 32'hdeadbeef at t → ready[2]=1 at t, wr_pending=1 at t+1, rd_addr=3 reads 32'hdeadbeef at t+2, 0 at t+1, wr_count=1.
- Fairness: all four valid continuously, addr=i, data=32'hcafe000i → grants 0,1,2,3,0,1… one per cycle; each entry i holds 32'hcafe000i; wr_count=8 after 8 cycles.
- Pointer skip/wrap: after grant to 3, only requesters 1 and 2 valid → grant 1 then 2; then only 0 valid → grant 0.
- Same-address collision: req 0 then req 1 write addr 5 with 32'h11111111, 32'h22222222 on consecutive cycles → entry 5 ends 32'h22222222.
- Reset mid-operation: accept write addr 7 data 32'hcafebabe, assert rst next cycle → entry 7 reads 0, wr_count=0, ptr=0 (next all-valid grant goes to 0).

Source files
------------

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared widths and helpers for the register write arbiter
package reg_arb_pkg;
  localparam int WR_CNT_W = 16;
  function automatic logic [WR_CNT_W-1:0] sat_inc(input logic [WR_CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/REGISTER_R_CE.sv
// REGISTER_R_CE: N-bit register with sync active-high reset and clock enable
// ports: q out, d in, ce enable, rst sync reset (to INIT), clk
module REGISTER_R_CE #(
  parameter int N = 1,
  parameter logic [N-1:0] INIT = '0
) (
  output logic [N-1:0] q,
  input  logic [N-1:0] d,
  input  logic         ce,
  input  logic         rst,
  input  logic         clk
);
  always_ff @(posedge clk) q <= rst ? INIT : ce ? d : q;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching req_i from ptr_i upward with wrap
// ports: req_i request vector, ptr_i priority start, gnt_o one-hot grant, gnt_idx_o winner index, gnt_vld_o any winner
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);
  always_comb begin
    int idx;
    idx = 0;
    gnt_o = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    // walk offsets from farthest to nearest so the nearest valid index overwrites
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[idx]) begin
        gnt_o = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o = PTR_W'(idx);
        gnt_vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter staging one write per cycle into a register bank
// ports: req_valid/req_ready handshake with packed req_addr/req_data, rd_addr -> rd_data comb read,
// wr_pending staged write present, wr_count saturating accepted-write count
module reg_write_arbiter import reg_arb_pkg::*; #(
  parameter int N = 32,
  parameter int NUM_REQ = 4,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*N-1:0]      req_data,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [N-1:0]              rd_data,
  output logic                      wr_pending,
  output logic [WR_CNT_W-1:0]       wr_count
);
  localparam int PTR_W = $clog2(NUM_REQ);
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      data;
  } stage_t;
  stage_t stage_q, stage_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic gnt_vld, acc;
  logic [WR_CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0] ent_q [DEPTH];
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .gnt_idx_o(gnt_idx),
    .gnt_vld_o(gnt_vld)
  );
  // nothing is granted or accepted while reset is held
  assign acc = gnt_vld & ~rst;
  assign req_ready = rst ? '0 : gnt;
  always_comb begin
    ptr_d = acc ? (gnt_idx == PTR_W'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    stage_d.valid = acc;
    stage_d.addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    stage_d.data = req_data[gnt_idx*N +: N];
    cnt_d = acc ? sat_inc(cnt_q) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      stage_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      stage_q <= stage_d;
      cnt_q <= cnt_d;
    end
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    REGISTER_R_CE #(.N(N)) u_ent (
      .q(ent_q[g]),
      .d(stage_q.data),
      .ce(stage_q.valid && stage_q.addr == ADDR_W'(g)),
      .rst(rst),
      .clk(clk)
    );
  end
  assign rd_data = ent_q[rd_addr];
  assign wr_pending = stage_q.valid;
  assign wr_count = cnt_q;
endmodule
